move_request_ctrl: RTL and testbench

//  Initiator for gameBoardDatapath: turns UP/DOWN/LEFT/RIGHT key presses into moveFrom/moveTo pairs.

---
 rtl/move_request_ctrl_pkg.sv | 47 ++++
 rtl/move_request_ctrl_key_edge_sync.sv | 26 ++
 rtl/move_request_ctrl.sv | 123 ++++++++++++
 tb/tb_move_request_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/move_request_ctrl_pkg.sv
// Shared definitions for the move request controller: board geometry, key directions,
// FSM state codes and the small board-index helpers.
package move_request_ctrl_pkg;

  localparam int POS_W   = 5;
  localparam int NIB_W   = 4;
  localparam int BOARD_N = 16;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dirT;

  localparam logic [2:0] ST_SCAN   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;

  typedef struct packed {
    logic       legal;
    logic [3:0] from;
  } moveCheckT;

  function automatic logic [NIB_W-1:0] nibbleAt(input logic [BOARD_N*NIB_W-1:0] board,
                                                input logic [3:0] idx);
    return board[{idx, 2'b00} +: NIB_W];
  endfunction

  // b is the 0-based blank index; the tile that slides into the blank sits at 'from'.
  function automatic moveCheckT checkMove(input dirT dir, input logic [3:0] b);
    moveCheckT r;
    r.legal = 1'b0;
    r.from  = b;
    case (dir)
      DIR_UP:    begin r.legal = (b[3:2] != 2'd3); r.from = b + 4'd4; end
      DIR_DOWN:  begin r.legal = (b[3:2] != 2'd0); r.from = b - 4'd4; end
      DIR_LEFT:  begin r.legal = (b[1:0] != 2'd3); r.from = b + 4'd1; end
      DIR_RIGHT: begin r.legal = (b[1:0] != 2'd0); r.from = b - 4'd1; end
      default:   r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/move_request_ctrl_key_edge_sync.sv
// Two-flop synchroniser for a raw key level followed by a rising-edge detector;
// press is high for one cycle per 0->1 transition of the key.
module key_edge_sync (
  input  logic clk,
  input  logic resetn,
  input  logic keyRaw,
  output logic press
);

  logic sync1, sync2, sync2Q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync2Q <= 1'b0;
    end else begin
      sync1  <= keyRaw;
      sync2  <= sync1;
      sync2Q <= sync2;
    end
  end

  assign press = sync2 & ~sync2Q;

endmodule

// File: rtl/move_request_ctrl.sv
// Turns key presses into moveFrom/moveTo requests for the game board datapath, tracking the
// blank tile (found by a serial scan after reset) and counting legal moves.
//
// state  | meaning
// SCAN   | walking block_state one nibble per cycle looking for the blank
// IDLE   | waiting for a press; locked (press rejected) while if_win is high
// CHECK  | edge-of-board legality test for the latched direction
// ISSUE  | move presented to the datapath for one cycle
// SETTLE | datapath register and if_win catch up
module move_request_ctrl
  import move_request_ctrl_pkg::*;
#(
  parameter logic [POS_W-1:0] INIT_BLANK_POS = 5'd16,
  parameter int               COUNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     key_up,
  input  logic                     key_down,
  input  logic                     key_left,
  input  logic                     key_right,
  input  logic [BOARD_N*NIB_W-1:0] block_state,
  input  logic                     if_win,
  output logic [POS_W-1:0]         move_from,
  output logic [POS_W-1:0]         move_to,
  output logic                     move_strobe,
  output logic                     rejected,
  output logic                     busy,
  output logic [POS_W-1:0]         blank_pos,
  output logic [COUNT_W-1:0]       move_count,
  output logic                     scan_err
);

  logic pressUp, pressDown, pressLeft, pressRight, anyPress;
  logic [2:0] state;
  logic [3:0] scanIdx, fromReg, bIdx;
  logic found, scanErr, issueNow, scanHit;
  logic [POS_W-1:0] blankPos;
  logic [COUNT_W-1:0] moveCount;
  dirT dirReg, pressDir;
  moveCheckT chk;

  key_edge_sync uSyncUp    (.clk(clk), .resetn(resetn), .keyRaw(key_up),    .press(pressUp));
  key_edge_sync uSyncDown  (.clk(clk), .resetn(resetn), .keyRaw(key_down),  .press(pressDown));
  key_edge_sync uSyncLeft  (.clk(clk), .resetn(resetn), .keyRaw(key_left),  .press(pressLeft));
  key_edge_sync uSyncRight (.clk(clk), .resetn(resetn), .keyRaw(key_right), .press(pressRight));

  assign anyPress = pressUp | pressDown | pressLeft | pressRight;

  always_comb begin
    pressDir = DIR_RIGHT;
    if (pressUp)        pressDir = DIR_UP;
    else if (pressDown) pressDir = DIR_DOWN;
    else if (pressLeft) pressDir = DIR_LEFT;
  end

  // Position 16 wraps to index 15 through the 4-bit subtract.
  assign bIdx    = blankPos[3:0] - 4'd1;
  assign chk     = checkMove(dirReg, bIdx);
  assign scanHit = (nibbleAt(block_state, scanIdx) == 4'd0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_SCAN;
      scanIdx   <= 4'd0;
      found     <= 1'b0;
      blankPos  <= INIT_BLANK_POS;
      fromReg   <= 4'd0;
      dirReg    <= DIR_UP;
      moveCount <= '0;
      scanErr   <= 1'b0;
    end else begin
      case (state)
        ST_SCAN: begin
          if (!found && scanHit) begin
            found    <= 1'b1;
            blankPos <= {1'b0, scanIdx} + 5'd1;
            if (({1'b0, scanIdx} + 5'd1) != INIT_BLANK_POS) scanErr <= 1'b1;
          end
          if (scanIdx == 4'(BOARD_N - 1)) begin
            state <= ST_IDLE;
            if (!found && !scanHit) scanErr <= 1'b1;
          end
          scanIdx <= scanIdx + 4'd1;
        end
        ST_IDLE: begin
          if (anyPress && !if_win) begin
            dirReg <= pressDir;
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (chk.legal) begin
            fromReg <= chk.from;
            state   <= ST_ISSUE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          blankPos <= {1'b0, fromReg} + 5'd1;
          if (moveCount != '1) moveCount <= moveCount + COUNT_W'(1);
          state <= ST_SETTLE;
        end
        ST_SETTLE: state <= ST_IDLE;
        default:   state <= ST_SCAN;
      endcase
    end
  end

  // Gated by resetn so a reset sampled during ISSUE never lets the move reach the datapath.
  assign issueNow    = (state == ST_ISSUE) && resetn;
  assign move_strobe = issueNow;
  assign move_to     = blankPos;
  assign move_from   = issueNow ? ({1'b0, fromReg} + 5'd1) : blankPos;
  assign rejected    = resetn && ((anyPress && ((state != ST_IDLE) || if_win)) ||
                                  ((state == ST_CHECK) && !chk.legal));
  assign busy        = (state != ST_IDLE);
  assign blank_pos   = blankPos;
  assign move_count  = moveCount;
  assign scan_err    = scanErr;

endmodule

// File: tb/tb_move_request_ctrl.sv
// Directed bench: two controllers (blank at 16 and blank at 1) each driving a small
// behavioural board model that slides a tile whenever move_from holds a tile and move_to the blank.
module tb_move_request_ctrl;

  localparam logic [63:0] SOLVED  = 64'h0FED_CBA9_8765_4321;
  localparam logic [63:0] SHIFTED = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] NOZERO  = 64'h1111_1111_1111_1111;
  localparam logic [3:0]  K_UP = 4'b0001, K_DOWN = 4'b0010, K_LEFT = 4'b0100, K_RIGHT = 4'b1000;

  logic clk = 1'b0;
  logic resetn;
  logic [3:0] keys0, keys1;
  logic ifWin;
  logic [63:0] board0, board1, initBoard0, initBoard1;

  logic [4:0] from0, to0, blank0, from1, to1, blank1;
  logic strobe0, rej0, busy0, err0, strobe1, rej1, busy1, err1;
  logic [15:0] count0, count1;

  int tests = 0;
  int fails = 0;
  int rejCnt0 = 0;
  int rejBase;

  always #5 clk = ~clk;

  move_request_ctrl #(.INIT_BLANK_POS(5'd16), .COUNT_W(16)) dut0 (
    .clk(clk), .resetn(resetn),
    .key_up(keys0[0]), .key_down(keys0[1]), .key_left(keys0[2]), .key_right(keys0[3]),
    .block_state(board0), .if_win(ifWin),
    .move_from(from0), .move_to(to0), .move_strobe(strobe0), .rejected(rej0),
    .busy(busy0), .blank_pos(blank0), .move_count(count0), .scan_err(err0)
  );

  move_request_ctrl #(.INIT_BLANK_POS(5'd1), .COUNT_W(16)) dut1 (
    .clk(clk), .resetn(resetn),
    .key_up(keys1[0]), .key_down(keys1[1]), .key_left(keys1[2]), .key_right(keys1[3]),
    .block_state(board1), .if_win(1'b0),
    .move_from(from1), .move_to(to1), .move_strobe(strobe1), .rejected(rej1),
    .busy(busy1), .blank_pos(blank1), .move_count(count1), .scan_err(err1)
  );

  function automatic logic [3:0] nib(input logic [63:0] b, input int pos);
    return b[(pos-1)*4 +: 4];
  endfunction

  function automatic logic [63:0] applyMove(input logic [63:0] b, input logic [4:0] f,
                                            input logic [4:0] t);
    logic [63:0] r;
    r = b;
    if (f != t && f >= 5'd1 && f <= 5'd16 && t >= 5'd1 && t <= 5'd16 &&
        nib(b, int'(f)) != 4'd0 && nib(b, int'(t)) == 4'd0) begin
      r[(int'(t)-1)*4 +: 4] = nib(b, int'(f));
      r[(int'(f)-1)*4 +: 4] = 4'd0;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      board0 <= initBoard0;
      board1 <= initBoard1;
    end else begin
      board0 <= applyMove(board0, from0, to0);
      board1 <= applyMove(board1, from1, to1);
      if (rej0) rejCnt0 <= rejCnt0 + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doMove0(input logic [3:0] m);
    keys0 = m;
    step(8);
    keys0 = 4'd0;
    step(4);
  endtask

  initial begin
    resetn = 1'b0; keys0 = 4'd0; keys1 = 4'd0; ifWin = 1'b0;
    initBoard0 = SOLVED; initBoard1 = SHIFTED;
    step(3);
    check("rst_busy", busy0, 1);
    check("rst_count", count0, 0);
    check("rst_blank", blank0, 16);
    check("rst_strobe", strobe0, 0);
    check("rst_from", from0, 16);
    check("rst_err", err0, 0);
    check("rst_blank1", blank1, 1);

    // Scan takes exactly 16 cycles
    resetn = 1'b1;
    step(15);
    check("scan_busy15", busy0, 1);
    step(1);
    check("scan_busy16", busy0, 0);
    check("scan_blank", blank0, 16);
    check("scan_err", err0, 0);
    check("scan_board", board0, SOLVED);
    check("scan_blank1", blank1, 1);
    check("scan_err1", err1, 0);

    // UP at bottom row is rejected in the CHECK cycle
    keys0 = K_UP;
    step(3);
    check("up_edge_rej", rej0, 1);
    check("up_edge_strobe", strobe0, 0);
    keys0 = 4'd0;
    step(4);
    check("up_edge_count", count0, 0);

    // RIGHT: tile 15 slides into position 16, 4-cycle latency
    keys0 = K_RIGHT;
    step(3);
    check("right_early", strobe0, 0);
    step(1);
    check("right_strobe", strobe0, 1);
    check("right_from", from0, 15);
    check("right_to", to0, 16);
    step(1);
    check("right_strobe_off", strobe0, 0);
    check("right_blank", blank0, 15);
    check("right_count", count0, 1);
    check("right_nib16", nib(board0, 16), 15);
    check("right_nib15", nib(board0, 15), 0);
    keys0 = 4'd0;
    step(4);

    // Blank at 1: LEFT legal, then DOWN off the top edge
    keys1 = K_LEFT;
    step(4);
    check("left1_strobe", strobe1, 1);
    check("left1_from", from1, 2);
    check("left1_to", to1, 1);
    step(1);
    check("left1_blank", blank1, 2);
    check("left1_count", count1, 1);
    keys1 = 4'd0;
    step(4);
    keys1 = K_DOWN;
    step(3);
    check("down1_rej", rej1, 1);
    keys1 = 4'd0;
    step(4);
    check("down1_count", count1, 1);
    check("down1_board", board1, 64'hFEDC_BA98_7654_3201);

    // Walk blank 15 -> 11 -> 7 -> 6, then UP+LEFT together
    doMove0(K_DOWN);
    doMove0(K_DOWN);
    doMove0(K_RIGHT);
    check("walk_blank", blank0, 6);
    check("walk_count", count0, 4);
    rejBase = rejCnt0;
    keys0 = K_UP | K_LEFT;
    step(4);
    check("dual_strobe", strobe0, 1);
    check("dual_from", from0, 10);
    check("dual_to", to0, 6);
    step(4);
    keys0 = 4'd0;
    step(4);
    check("dual_count", count0, 5);
    check("dual_blank", blank0, 10);
    check("dual_norej", rejCnt0, rejBase);
    check("dual_nib6", nib(board0, 6), 10);
    check("dual_nib10", nib(board0, 10), 0);

    // Press landing in SETTLE is dropped with a rejected pulse
    rejBase = rejCnt0;
    keys0 = K_DOWN;
    step(3);
    keys0 = K_DOWN | K_UP;
    step(6);
    keys0 = 4'd0;
    step(4);
    check("settle_count", count0, 6);
    check("settle_blank", blank0, 6);
    check("settle_rej", rejCnt0, rejBase + 1);

    // Locked while if_win is high
    ifWin = 1'b1;
    rejBase = rejCnt0;
    keys0 = K_LEFT;
    step(2);
    check("win_rej", rej0, 1);
    check("win_noop", from0, to0);
    step(4);
    keys0 = 4'd0;
    step(4);
    check("win_count", count0, 6);
    check("win_blank", blank0, 6);
    check("win_rejcnt", rejCnt0, rejBase + 1);
    check("win_nib6", nib(board0, 6), 0);
    check("win_nib10", nib(board0, 10), 10);
    ifWin = 1'b0;

    // Reset sampled during ISSUE, then rescan of a board with no blank
    initBoard0 = NOZERO;
    keys0 = K_RIGHT;
    step(4);
    check("mid_pre_strobe", strobe0, 1);
    resetn = 1'b0;
    #1;
    check("mid_strobe", strobe0, 0);
    check("mid_noop", from0, to0);
    keys0 = 4'd0;
    step(2);
    resetn = 1'b1;
    step(15);
    check("rescan_busy15", busy0, 1);
    step(1);
    check("rescan_busy", busy0, 0);
    check("rescan_err", err0, 1);
    check("rescan_blank", blank0, 16);
    check("rescan_count", count0, 0);
    check("rescan_board", board0, NOZERO);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
